// File: rtl/ad_trig_capture.sv
// ad_trig_capture
//   Captures one fixed-length ADC record around a trigger and streams it out.
//   Samples pass through a two-stage input pipeline (register, then
//   offset-binary to two's-complement conversion) and are written into a
//   circular buffer. After an arm request the buffer collects a pre-trigger
//   window, waits for a level crossing or a forced trigger, collects the
//   post-trigger samples, then replays the whole record over valid/ready.
//
// Ports
//   sys_clk, sys_rst_n      sample clock, async active-low reset
//   ad_data, ad_otr         raw ADC sample and out-of-range flag
//   arm                     single-cycle capture request (honoured in IDLE only)
//   force_trig              immediate trigger (honoured in WAIT_TRIG only)
//   trig_edge, trig_level   0 = rising / 1 = falling crossing of a signed level
//   busy, done              not-idle flag, one-cycle end-of-readout pulse
//   otr_cnt                 saturating count of written samples with otr set
//   m_data/m_valid/m_ready/m_last   record readout stream, m_data = {otr, sample}
module ad_trig_capture #(
    parameter int DATA_W     = 14,
    parameter int DEPTH_LOG2 = 10,
    parameter int PRE_TRIG   = 256,
    parameter int SIGNED_OUT = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] ad_data,
    input  logic              ad_otr,
    input  logic              arm,
    input  logic              force_trig,
    input  logic              trig_edge,
    input  logic [DATA_W-1:0] trig_level,
    output logic              busy,
    output logic              done,
    output logic [15:0]       otr_cnt,
    output logic [DATA_W:0]   m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    localparam int AW     = DEPTH_LOG2;
    localparam int DEPTH  = 1 << AW;
    localparam int POST_N = DEPTH - PRE_TRIG - 1;
    localparam int STAGES = 2;

    typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, READ} state_t;

    typedef struct packed {
        logic              otr;
        logic [DATA_W-1:0] d;
    } smp_t;

    function automatic logic [DATA_W-1:0] conv(input logic [DATA_W-1:0] x);
        conv = x;
        if (SIGNED_OUT != 0) conv[DATA_W-1] = ~x[DATA_W-1];
    endfunction

    // ---------------------------------------------------------------
    // Input pipeline. vld_pipe tracks how far real samples have
    // propagated since reset; vld_pipe[STAGES] means the previous s2
    // sample is genuine, so the crossing detector may use it.
    // ---------------------------------------------------------------
    logic [STAGES:0]   vld_pipe;
    smp_t              s1, s2_cur;
    logic [DATA_W-1:0] s2_prev;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vld_pipe <= '0;
            s1       <= '0;
            s2_cur   <= '0;
            s2_prev  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
            s1       <= {ad_otr, ad_data};
            s2_cur   <= {s1.otr, conv(s1.d)};
            s2_prev  <= s2_cur.d;
        end
    end

    logic rise, fall, trig;
    always_comb begin
        rise = ($signed(s2_prev) < $signed(trig_level)) &&
               ($signed(s2_cur.d) >= $signed(trig_level));
        fall = ($signed(s2_prev) > $signed(trig_level)) &&
               ($signed(s2_cur.d) <= $signed(trig_level));
        trig = force_trig || (vld_pipe[STAGES] && (trig_edge ? fall : rise));
    end

    // ---------------------------------------------------------------
    // Control / readout state
    // ---------------------------------------------------------------
    state_t          state;
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   cnt;
    logic [AW-1:0]   rd_addr;
    logic [AW:0]     iss_cnt;   // reads issued to the RAM
    logic [AW-1:0]   ld_cnt;    // samples moved into the output register
    logic            rd_pend;   // ram_q holds a sample not yet loaded
    logic [DATA_W:0] ram_q;
    logic            we, re, load;

    assign busy = (state != IDLE);

    // load: the output register is free to take a new sample this edge.
    // A new read is only issued when ram_q will be consumed or is empty,
    // so ram_q never has to be overwritten while stalled.
    always_comb begin
        we   = (state == PRE) || (state == WAIT_TRIG) || (state == POST);
        load = !m_valid || m_ready;
        re   = (state == READ) && (iss_cnt != (AW+1)'(DEPTH)) && (!rd_pend || load);
    end

    logic [DATA_W:0] mem [DEPTH];

    always_ff @(posedge sys_clk) begin
        if (we) mem[wptr] <= s2_cur;
        if (re) ram_q <= mem[rd_addr];
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= IDLE;
            wptr    <= '0;
            cnt     <= '0;
            rd_addr <= '0;
            iss_cnt <= '0;
            ld_cnt  <= '0;
            rd_pend <= 1'b0;
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            done    <= 1'b0;
            otr_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (we) begin
                wptr <= wptr + 1'b1;
                if (s2_cur.otr && otr_cnt != 16'hFFFF) otr_cnt <= otr_cnt + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (arm) begin
                        state   <= PRE;
                        wptr    <= '0;
                        cnt     <= '0;
                        otr_cnt <= '0;
                    end
                end
                PRE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == AW'(PRE_TRIG - 1)) state <= WAIT_TRIG;
                end
                WAIT_TRIG: begin
                    if (trig) begin
                        // The trigger sample lands at wptr; the record starts
                        // PRE_TRIG entries before it, modulo the buffer size.
                        rd_addr <= wptr - AW'(PRE_TRIG);
                        cnt     <= '0;
                        iss_cnt <= '0;
                        ld_cnt  <= '0;
                        rd_pend <= 1'b0;
                        state   <= (POST_N == 0) ? READ : POST;
                    end
                end
                POST: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == AW'(POST_N - 1)) state <= READ;
                end
                READ: begin
                    if (re) begin
                        rd_addr <= rd_addr + 1'b1;
                        iss_cnt <= iss_cnt + 1'b1;
                    end
                    if (m_valid && m_ready && m_last) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end else if (load) begin
                        if (rd_pend) begin
                            m_data  <= ram_q;
                            m_valid <= 1'b1;
                            m_last  <= (ld_cnt == AW'(DEPTH - 1));
                            ld_cnt  <= ld_cnt + 1'b1;
                        end else begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                        end
                    end
                    rd_pend <= re ? 1'b1 : (load ? 1'b0 : rd_pend);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ad_trig_capture.sv
// Testbench for ad_trig_capture (DEPTH_LOG2 = 4, PRE_TRIG = 4, SIGNED_OUT = 1).
// Every cycle's pin inputs are logged; after each capture a reference model
// locates the trigger in that log and predicts the record and otr count.
module tb_ad_trig_capture;

    localparam int DW    = 14;
    localparam int DEPTH = 16;
    localparam int PRE   = 4;
    localparam int LOGN  = 4096;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic [DW-1:0] ad_data;
    logic          ad_otr;
    logic          arm;
    logic          force_trig;
    logic          trig_edge;
    logic [DW-1:0] trig_level;
    logic          busy, done, m_valid, m_ready, m_last;
    logic [15:0]   otr_cnt;
    logic [DW:0]   m_data;

    ad_trig_capture #(.DATA_W(DW), .DEPTH_LOG2(4), .PRE_TRIG(PRE), .SIGNED_OUT(1)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ad_data(ad_data), .ad_otr(ad_otr),
        .arm(arm), .force_trig(force_trig), .trig_edge(trig_edge), .trig_level(trig_level),
        .busy(busy), .done(done), .otr_cnt(otr_cnt), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // stimulus generator controls
    int step   = 0;
    bit rnd    = 1'b0;
    bit bp     = 1'b0;
    int rdy_ph = 0;
    int otr_lo = -1;
    int otr_hi = -1;

    // input log (index = cycle number) and output monitor
    logic [DW-1:0] log_d [0:LOGN-1];
    logic          log_o [0:LOGN-1];
    logic          log_f [0:LOGN-1];
    int            ncyc = 0;
    logic [DW:0]   rx_d [0:LOGN-1];
    logic          rx_l [0:LOGN-1];
    int            rx_n = 0;
    int            done_cnt = 0;
    int            stall_viol = 0;
    logic          stall_prev = 1'b0;
    logic [DW:0]   pd = '0;
    logic          pl = 1'b0;

    always @(negedge sys_clk) begin
        if (ncyc < LOGN) begin
            log_d[ncyc] <= ad_data;
            log_o[ncyc] <= ad_otr;
            log_f[ncyc] <= force_trig;
        end
        ncyc <= ncyc + 1;
        if (m_valid === 1'b1 && m_ready === 1'b1 && rx_n < LOGN) begin
            rx_d[rx_n] <= m_data;
            rx_l[rx_n] <= m_last;
            rx_n       <= rx_n + 1;
        end
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (stall_prev && !(m_valid === 1'b1 && m_data === pd && m_last === pl))
            stall_viol <= stall_viol + 1;
        stall_prev <= (m_valid === 1'b1) && (m_ready === 1'b0);
        pd <= m_data;
        pl <= m_last;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one cycle; new inputs are applied just after the rising edge
    task automatic tick();
        @(posedge sys_clk);
        #1;
        if (rnd) ad_data = DW'($urandom);
        else     ad_data = ad_data + DW'(step);
        ad_otr  = (ncyc >= otr_lo) && (ncyc < otr_hi);
        m_ready = bp ? (rdy_ph % 3 == 0) : 1'b1;
        rdy_ph++;
    endtask

    // ---------------- reference model ----------------
    logic [DW:0] exp_rec [0:DEPTH-1];
    int          exp_otr;
    bit          exp_found;

    // signed value of an offset-binary code
    function automatic int sv(input int c);
        return int'(log_d[c]) - 8192;
    endfunction

    // A sample driven in cycle n reaches the buffer two cycles later; arm
    // driven in cycle a starts writing with the sample of cycle a-1. The
    // first PRE_TRIG written samples can't trigger; a candidate sample c
    // is judged when force_trig of cycle c+2 is visible.
    task automatic model(input int a_idx);
        int fw, k, lvl;
        fw = a_idx - 1;
        lvl = int'($signed(trig_level));
        exp_found = 1'b0;
        k = fw + PRE;
        for (int c = fw + PRE; c < fw + PRE + 300 && !exp_found; c++) begin
            if (log_f[c+2] === 1'b1 ||
                (trig_edge == 1'b0 ? (sv(c-1) < lvl && sv(c) >= lvl)
                                   : (sv(c-1) > lvl && sv(c) <= lvl))) begin
                exp_found = 1'b1;
                k = c;
            end
        end
        for (int i = 0; i < DEPTH; i++)
            exp_rec[i] = {log_o[k-PRE+i], DW'(log_d[k-PRE+i] + 14'h2000)};
        exp_otr = 0;
        for (int c = fw; c <= k + DEPTH - PRE - 1; c++) exp_otr += int'(log_o[c]);
    endtask

    task automatic arm_cap(input bit frc, output int a_idx, output int rx0, output int d0);
        rx0 = rx_n;
        d0 = done_cnt;
        a_idx = ncyc;
        arm = 1'b1;
        force_trig = frc;
        tick();
        arm = 1'b0;
    endtask

    task automatic finish_cap(input string tag, input int a_idx, input int rx0, input int d0);
        for (int t = 0; t < 400 && done_cnt == d0; t++) tick();
        check({tag, "_timeout"}, done_cnt != d0, 1);
        tick();
        tick();
        model(a_idx);
        check({tag, "_trig_found"}, exp_found, 1);
        check({tag, "_count"}, rx_n - rx0, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("%s_d%0d", tag, i), rx_d[rx0+i], exp_rec[i]);
            check($sformatf("%s_last%0d", tag, i), rx_l[rx0+i], (i == DEPTH - 1));
        end
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_otr_cnt"}, otr_cnt, exp_otr);
        check({tag, "_stall_stable"}, stall_viol, 0);
    endtask

    int a, r, d, n;

    initial begin
        ad_data = '0; ad_otr = 1'b0; arm = 1'b0; force_trig = 1'b0;
        trig_edge = 1'b0; trig_level = '0; m_ready = 1'b1;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", m_valid, 0);
        check("rst_last", m_last, 0);
        check("rst_data", m_data, 0);
        check("rst_otr_cnt", otr_cnt, 0);
        sys_rst_n = 1'b1;
        repeat (4) tick();

        // 1: rising crossing of a ramp
        step = 1; ad_data = 14'h1FF0;
        arm_cap(1'b0, a, r, d);
        finish_cap("ramp", a, r, d);
        check("ramp_s0", rx_d[r], 15'h3FFC);
        check("ramp_s3", rx_d[r+3], 15'h3FFF);
        check("ramp_s4", rx_d[r+4], 15'h0000);
        check("ramp_s15", rx_d[r+15], 15'h000B);

        // 2: forced trigger, arm and force in the same idle cycle
        step = 0; ad_data = 14'h2100; tick();
        arm_cap(1'b1, a, r, d);
        finish_cap("force", a, r, d);
        force_trig = 1'b0;
        for (int i = 0; i < DEPTH; i++) check($sformatf("force_const%0d", i), rx_d[r+i], 15'h0100);

        // 3: falling crossing
        step = -1; ad_data = 14'h2010; trig_level = 14'h0005; trig_edge = 1'b1;
        arm_cap(1'b0, a, r, d);
        finish_cap("fall", a, r, d);
        check("fall_s4", rx_d[r+4], 15'h0005);
        check("fall_s3", rx_d[r+3], 15'h0006);
        trig_edge = 1'b0; trig_level = '0;

        // 4: ramp again under backpressure 1,0,0,...
        step = 1; ad_data = 14'h1FF0; bp = 1'b1; rdy_ph = 0;
        arm_cap(1'b0, a, r, d);
        finish_cap("bp", a, r, d);
        check("bp_s0", rx_d[r], 15'h3FFC);
        check("bp_s4", rx_d[r+4], 15'h0000);
        check("bp_s15", rx_d[r+15], 15'h000B);
        bp = 1'b0;

        // 5: ten out-of-range samples inside the captured window
        rnd = 1'b1; step = 0;
        otr_lo = ncyc + 2; otr_hi = ncyc + 12;
        arm_cap(1'b1, a, r, d);
        finish_cap("otr", a, r, d);
        force_trig = 1'b0;
        check("otr_cnt10", otr_cnt, 10);
        n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(rx_d[r+i][DW]);
        check("otr_flagged", n, 10);
        otr_lo = -1; otr_hi = -1;

        // 6a: a second arm during POST must not restart the capture
        arm_cap(1'b1, a, r, d);
        repeat (9) tick();
        arm = 1'b1; tick(); arm = 1'b0;
        finish_cap("rearm", a, r, d);
        force_trig = 1'b0;

        // 6b: reset pulsed during POST
        rnd = 1'b0; ad_data = 14'h2100; tick();
        arm_cap(1'b1, a, r, d);
        repeat (9) tick();
        check("pre_rst_busy", busy, 1);
        sys_rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_last", m_last, 0);
        check("mid_rst_data", m_data, 0);
        check("mid_rst_otr_cnt", otr_cnt, 0);
        tick();
        sys_rst_n = 1'b1; force_trig = 1'b0;
        repeat (4) tick();
        check("post_rst_busy", busy, 0);

        // 6c: clean capture after the reset
        arm_cap(1'b1, a, r, d);
        finish_cap("after_rst", a, r, d);
        force_trig = 1'b0;
        for (int i = 0; i < DEPTH; i++) check($sformatf("after_rst_const%0d", i), rx_d[r+i], 15'h0100);

        // 7: random data, random level and edge
        rnd = 1'b1;
        for (int j = 0; j < 4; j++) begin
            trig_level = DW'(int'($urandom_range(0, 8000)) - 4000);
            trig_edge = 1'($urandom_range(0, 1));
            bp = 1'($urandom_range(0, 1));
            arm_cap(1'b0, a, r, d);
            finish_cap($sformatf("rand%0d", j), a, r, d);
        end
        bp = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ad_trig_capture.md
Name: ad_trig_capture

Overview:
Downstream consumer of the 14-bit ADC port clocked by the PLL-derived 65 MHz AD clock. Registers ADC samples and out-of-range flags, converts offset-binary to two's complement, and fills a circular buffer with a programmable pre-trigger window. Captures a fixed-length record around a level-crossing or forced trigger, then streams the record out over a valid/ready interface for downstream processing or debug readout.

Parameters:
DATA_W, 14, ADC sample width.
DEPTH_LOG2, 10, log2 of record length; DEPTH = 2^DEPTH_LOG2 samples.
PRE_TRIG, 256, number of samples preceding the trigger sample in the record; legal range 1 to DEPTH-1.
SIGNED_OUT, 1, 1 = invert the sample MSB (offset-binary to two's complement); 0 = pass raw.

Ports:
sys_clk  in  1  sample clock, same frequency and phase as the ADC drive clock.
sys_rst_n  in  1  asynchronous active-low reset.
ad_data  in  DATA_W  raw ADC sample.
ad_otr  in  1  ADC out-of-range flag; 1 = over range.
arm  in  1  single-cycle start request.
force_trig  in  1  immediate trigger request.
trig_edge  in  1  0 = rising crossing, 1 = falling crossing.
trig_level  in  DATA_W  signed threshold, compared after conversion.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse after the last readout handshake.
otr_cnt  out  16  saturating count of captured samples with otr set.
m_data  out  DATA_W+1  {otr, converted sample}.
m_valid  out  1  readout data valid.
m_ready  in  1  downstream ready.
m_last  out  1  marks the final record sample.

Behaviour:
- Reset: busy, done, m_valid and m_last = 0; m_data = 0; otr_cnt = 0; state = IDLE. Asserting reset mid-operation aborts to IDLE. RAM contents are don't-care.
- Input pipeline:
  - s1 registers ad_data and ad_otr.
  - s2 applies the conversion and holds the previous s2 sample for edge detection.
  - The buffer write uses s2, so a pin sample is written 2 cycles after it is sampled.
- Buffer: DEPTH x (DATA_W+1) simple dual-port RAM with 1-cycle registered read. The write pointer wraps modulo DEPTH.
- IDLE: no writes. arm → PRE; write pointer cleared; otr_cnt cleared.
- PRE:
  - Writes every cycle and counts writes.
  - After PRE_TRIG writes → WAIT_TRIG.
  - Triggers asserted during PRE are ignored, not latched.
- WAIT_TRIG:
  - Writes every cycle, wrapping.
  - Trigger fires when force_trig = 1, or on a crossing.
  - Rising crossing: prev < trig_level and cur >= trig_level, signed compare.
  - Falling crossing: prev > trig_level and cur <= trig_level.
  - The trigger sample is the current s2 sample; it is written and its address latched as taddr.
  - Next state → POST.
- POST: writes DEPTH-PRE_TRIG-1 further samples, then → READ. Record start address = (taddr - PRE_TRIG) mod DEPTH.
- READ:
  - Streams DEPTH samples in order from the start address, wrapping.
  - m_valid rises within 2 cycles of entering READ.
  - m_data, m_valid and m_last are held stable while m_valid & !m_ready.
  - A transfer occurs when m_valid & m_ready.
  - m_last is high only on the DEPTH-th sample.
  - After the last transfer: m_valid = 0, done pulses for 1 cycle, state → IDLE.
- No buffer writes occur in READ or IDLE.
- otr_cnt increments on each buffer write with otr = 1, saturating at 0xFFFF.
- arm received while busy is ignored. arm and force_trig asserted in the same IDLE cycle: arm is taken, force_trig is ignored.
- Simultaneous force_trig and a level crossing count as one trigger.

Test Plan:
Bench settings: DEPTH_LOG2 = 4, PRE_TRIG = 4, SIGNED_OUT = 1, m_ready = 1 unless stated.
1. Ramp trigger: ad_data ramps by +1 per cycle from 0x1FF0; trig_level = 0; trig_edge = 0; arm → 16 samples.
   - Samples 0–3 = 0x3FFC..0x3FFF; sample 4 = 0x0000; sample 15 = 0x000B.
   - m_last on sample 15; one done pulse.
2. Forced trigger: ad_data = 0x2100 constant; arm; force_trig held high → 16 samples, all m_data = 0x0100; busy returns to 0 after done.
3. Falling edge: ad_data ramps by −1 from 0x2010; trig_level = 0x0005; trig_edge = 1 → sample 4 = 0x0005 and sample 3 = 0x0006.
4. Backpressure: repeat test 1 with m_ready toggling 1,0,0,1,… → same 16 values in order; each delivered once; m_data unchanged during stalls.
5. OTR: ad_otr high for 10 cycles within the captured window → otr_cnt = 10; exactly those 10 samples have m_data[14] = 1.
6. Control robustness:
   - A second arm during POST is ignored.
   - sys_rst_n pulsed low in POST → all outputs 0 immediately.
   - A subsequent arm produces a correct record matching test 2.
